// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and defaults for the mul/div sequencer.
//  state_t            FSM state encoding (7 states in 3 bits; code 7 is illegal)
//  OP_MUL / OP_DIV    encodings of the op input
//  MUL_STEPS_DEF      shift-add iterations per multiply
//  DIV_STEPS_DEF      quotient bits produced per divide
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    WRITE = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int MUL_STEPS_DEF = 4;
  localparam int DIV_STEPS_DEF = 5;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: control bundle between the sequencer, the key FSM and
// the shared shift register / ALU datapath.
//  key FSM  -> seq : start, op, divisor_zero
//  datapath -> seq : c, borrow
//  seq -> datapath : ld_multiplier, ld_dividend, alu_sub, wr_result, sh, q_in
//  seq -> key FSM  : busy, done, err
// master = sequencer side, slave = its environment.
interface muldiv_sequencer_if;

  logic start;
  logic op;
  logic c;
  logic borrow;
  logic divisor_zero;
  logic ld_multiplier;
  logic ld_dividend;
  logic alu_sub;
  logic wr_result;
  logic sh;
  logic q_in;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  start, op, c, borrow, divisor_zero,
    output ld_multiplier, ld_dividend, alu_sub, wr_result, sh, q_in,
           busy, done, err
  );

  modport slave (
    output start, op, c, borrow, divisor_zero,
    input  ld_multiplier, ld_dividend, alu_sub, wr_result, sh, q_in,
           busy, done, err
  );

endinterface

// File: rtl/muldiv_step_counter.sv
// muldiv_step_counter: iteration counter for the sequencer.
//  clk    in  clock, rising edge
//  rst    in  synchronous active-high reset (counter -> 0)
//  clr    in  synchronous clear (counter -> 0)
//  inc    in  increment by one
//  limit  in  index of the final step
//  last   out counter currently equals limit
module muldiv_step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign last = (cnt == limit);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: control FSM for the shared mul/div shift register + ALU.
// Runs a 4x4 shift-add multiply or an 8/4 restoring divide by strobing the
// datapath, and reports completion to the key FSM with a one-cycle done pulse.
//  clk  in   clock, rising edge
//  rst  in   synchronous active-high reset; aborts any operation in flight
//  bus  master modport of muldiv_sequencer_if (handshake + datapath strobes)
// All outputs are Moore decodes of state, op_r and qbit_r.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_STEPS = MUL_STEPS_DEF,
  parameter int DIV_STEPS = DIV_STEPS_DEF,
  parameter int CNT_W     = 3
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.master bus
);

  state_t state, state_nx;
  logic   op_r, op_nx;
  logic   qbit_r, qbit_nx;
  logic   cnt_last;

  // Limit follows the captured op, so the counter never runs past the
  // longer of the two step counts.
  logic [CNT_W-1:0] limit;
  assign limit = (op_r == OP_DIV) ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MUL_STEPS - 1);

  muldiv_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == LOAD),
    .inc   (state == SHIFT),
    .limit (limit),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= OP_MUL;
      qbit_r <= 1'b0;
    end else begin
      state  <= state_nx;
      op_r   <= op_nx;
      qbit_r <= qbit_nx;
    end
  end

  // Next state
  always_comb begin
    state_nx = IDLE;
    op_nx    = op_r;
    qbit_nx  = qbit_r;
    case (state)
      IDLE: begin
        state_nx = IDLE;
        if (bus.start) begin
          state_nx = LOAD;
          op_nx    = bus.op;
        end
      end
      LOAD: begin
        qbit_nx  = 1'b0;
        state_nx = (op_r == OP_DIV && bus.divisor_zero) ? ERR : TEST;
      end
      TEST: begin
        if (op_r == OP_DIV) begin
          // Trial subtraction fits -> commit it and shift in a 1.
          qbit_nx  = ~bus.borrow;
          state_nx = bus.borrow ? SHIFT : WRITE;
        end else begin
          state_nx = bus.c ? WRITE : SHIFT;
        end
      end
      WRITE:   state_nx = SHIFT;
      SHIFT:   state_nx = cnt_last ? DONE : TEST;
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.ld_multiplier = 1'b0;
    bus.ld_dividend   = 1'b0;
    bus.alu_sub       = 1'b0;
    bus.wr_result     = 1'b0;
    bus.sh            = 1'b0;
    bus.q_in          = 1'b0;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.err           = 1'b0;
    case (state)
      LOAD: begin
        bus.busy          = 1'b1;
        bus.ld_multiplier = (op_r == OP_MUL);
        bus.ld_dividend   = (op_r == OP_DIV);
      end
      TEST: begin
        bus.busy    = 1'b1;
        bus.alu_sub = op_r;
      end
      WRITE: begin
        bus.busy      = 1'b1;
        bus.wr_result = 1'b1;
        bus.alu_sub   = op_r;
      end
      SHIFT: begin
        bus.busy = 1'b1;
        bus.sh   = 1'b1;
        bus.q_in = op_r & qbit_r;
      end
      DONE: bus.done = 1'b1;
      ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: self-checking bench for muldiv_sequencer.
// The bench plays the datapath: c is the multiplier bit currently at the LSB
// (y shifted right once per sh), borrow comes from a per-step table. Expected
// latencies, strobe counts and quotient bits are computed from the operation's
// arithmetic rules, not from the FSM structure.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus();

  muldiv_sequencer #(.MUL_STEPS(4), .DIV_STEPS(5), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.ld_multiplier, bus.ld_dividend, bus.alu_sub, bus.wr_result,
            bus.sh, bus.q_in, bus.busy, bus.done, bus.err};
  endfunction

  // Runs one operation; start is raised at cycle 0. With hold=1 start stays
  // high and op switches to nxt_op right after capture (the DUT must ignore it).
  task automatic run_op(input string tag, input logic op_i, input logic [3:0] y,
                        input logic [4:0] bq, input logic dz,
                        input logic hold, input logic nxt_op);
    int exp_cyc, exp_sh, exp_wr, nsh, nwr, nldm, nldd, bad, donecyc, ldcyc;
    logic [4:0] qv, exp_qv;
    logic [3:0] ys;
    logic [4:0] bs;
    logic       errv;
    if (op_i == 1'b0) begin
      exp_sh = 4; exp_wr = $countones(y); exp_qv = '0;
      exp_cyc = 2 + 2 * 4 + exp_wr;
    end else if (dz) begin
      exp_sh = 0; exp_wr = 0; exp_qv = '0; exp_cyc = 2;
    end else begin
      exp_qv = ~bq; exp_sh = 5; exp_wr = $countones(exp_qv);
      exp_cyc = 2 + 2 * 5 + exp_wr;
    end
    nsh = 0; nwr = 0; nldm = 0; nldd = 0; bad = 0; donecyc = 0; ldcyc = 0;
    qv = '0; errv = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op_i; bus.divisor_zero = dz;
    bus.c = y[0]; bus.borrow = bq[0];
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) bus.op = nxt_op;
        else      bus.start = 1'b0;
      end
      if ($countones({bus.ld_multiplier, bus.ld_dividend, bus.wr_result, bus.sh}) > 1) bad++;
      if (bus.ld_multiplier) begin nldm++; ldcyc = k; end
      if (bus.ld_dividend)   begin nldd++; ldcyc = k; end
      if (bus.wr_result) begin
        nwr++;
        if (bus.alu_sub !== op_i) bad++;
      end
      if (!op_i && bus.alu_sub) bad++;
      // A divide trial-subtract cycle: busy, no strobe, past the load.
      if (op_i && !dz && k > 1 && bus.busy && !bus.sh && !bus.wr_result && !bus.alu_sub) bad++;
      if (bus.sh) begin
        if (nsh < 5) qv[nsh] = bus.q_in;
        nsh++;
      end
      if (bus.done) begin
        donecyc = k; errv = bus.err;
        if (bus.busy) bad++;
        break;
      end
      if (!bus.busy) bad++;
      ys = y >> nsh;  bus.c = ys[0];
      bs = bq >> nsh; bus.borrow = bs[0];
    end
    chk({tag, "/done_cyc"}, donecyc, exp_cyc);
    chk({tag, "/err"}, errv, op_i & dz);
    chk({tag, "/sh_cnt"}, nsh, exp_sh);
    chk({tag, "/wr_cnt"}, nwr, exp_wr);
    chk({tag, "/ld_cyc"}, ldcyc, 1);
    chk({tag, "/ld_kind"}, {nldm[7:0], nldd[7:0]}, op_i ? 16'h0001 : 16'h0100);
    chk({tag, "/q_bits"}, qv, exp_qv);
    chk({tag, "/protocol"}, bad, 0);
    if (!hold) begin
      @(negedge clk);
      chk({tag, "/idle_after"}, outs(), 9'h0);
    end
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.op = 1'b0; bus.c = 1'b0; bus.borrow = 1'b0;
    bus.divisor_zero = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/outs", outs(), 9'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset/idle", outs(), 9'h0);

    // Directed cases
    run_op("mul_y0", 1'b0, 4'h0, 5'h0, 1'b0, 1'b0, 1'b0);
    run_op("mul_yF", 1'b0, 4'hF, 5'h0, 1'b0, 1'b0, 1'b0);
    // borrow per step 1,0,1,0,0 -> quotient bits 0,1,0,1,1
    run_op("div_b10100", 1'b1, 4'h0, 5'b00101, 1'b0, 1'b0, 1'b0);
    run_op("div_zero", 1'b1, 4'h0, 5'h0, 1'b1, 1'b0, 1'b0);

    // start toggled while busy, then rst mid-TEST
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.divisor_zero = 1'b0; bus.c = 1'b1;
    n = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = k[0];
      if (k > 1 && (bus.ld_multiplier || bus.ld_dividend)) n++;
    end
    chk("abort/no_restart", n, 0);
    chk("abort/busy_mid", bus.busy, 1'b1);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    chk("abort/outs_rst", outs(), 9'h0);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("abort/idle", outs(), 9'h0);
    run_op("after_abort", 1'b0, 4'h5, 5'h0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held through DONE, op re-sampled in IDLE
    run_op("b2b_first", 1'b0, 4'h3, 5'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("b2b/idle_gap", outs(), 9'h0);
    @(negedge clk);
    chk("b2b/reload", {bus.ld_multiplier, bus.ld_dividend, bus.busy}, 3'b011);
    bus.start = 1'b0; bus.borrow = 1'b0;
    // all borrows 0 -> five 1-bits: done 17 cycles after start, 16 after load
    n = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin n = k; break; end
    end
    chk("b2b/second_done", n, 17);

    // Randomized operations
    for (int i = 0; i < 8; i++) begin
      logic [3:0] ry;
      ry = 4'($urandom);
      run_op($sformatf("rmul%0d", i), 1'b0, ry, 5'h0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      logic [4:0] rb;
      logic       rz;
      rb = 5'($urandom);
      rz = ($urandom_range(0, 3) == 0);
      run_op($sformatf("rdiv%0d", i), 1'b1, 4'h0, rb, rz, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
